// File: rtl/fft_frame_sequencer.sv
// Streams 16 complex samples into the 4-wide fft_16_4 core as five back-to-back beats,
// then drains the 16 captured results one bin per cycle.
module fft_frame_sequencer #(
  parameter int IW = 8,
  parameter int OW = IW + 4
) (
  input  logic                 clk,
  input  logic                 rst_sync,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [IW-1:0] s_data [2],
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [OW-1:0] m_data [2],
  output logic [3:0]           m_index,
  output logic                 m_last,
  output logic                 err,
  output logic                 fft_rst_sync_n,
  output logic                 fft_i_valid,
  output logic signed [IW-1:0] fft_i_data [4][2],
  input  logic                 fft_o_valid,
  input  logic signed [OW-1:0] fft_o_data [16][2]
);

  typedef enum logic [1:0] {FILL, FULL, ISSUE, WAIT} in_state_t;
  typedef enum logic {IDLE, DRAIN} out_state_t;

  in_state_t  in_state;
  out_state_t out_state;

  logic signed [IW-1:0] frame_buf [16][2];
  logic signed [OW-1:0] bin_buf [16][2];

  logic [3:0] wr_cnt;
  logic [3:0] rd_cnt;
  logic [3:0] rd_next;
  logic [2:0] beat;
  logic [1:0] wait_cnt;
  logic [1:0] next_group;
  logic       s_fire;
  logic       m_fire;
  logic       out_free;
  logic       start_drain;

  assign fft_rst_sync_n = ~rst_sync;
  assign s_fire         = s_valid & s_ready;
  assign m_fire         = m_valid & m_ready;
  assign rd_next        = rd_cnt + 4'd1;
  assign start_drain    = (in_state == WAIT) & fft_o_valid;

  // The output side counts as free in the cycle its final bin is accepted, so the
  // next frame can issue immediately afterwards.
  assign out_free = (out_state == IDLE) | (m_fire & (rd_cnt == 4'd15));

  // Group of four frame slots to present on the next beat; FILL/FULL start at group 0.
  assign next_group = (in_state == ISSUE) ? (beat[1:0] + 2'd1) : 2'd0;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      in_state    <= FILL;
      s_ready     <= 1'b1;
      wr_cnt      <= '0;
      beat        <= '0;
      wait_cnt    <= '0;
      fft_i_valid <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int c = 0; c < 2; c++) begin
          fft_i_data[i][c] <= '0;
        end
      end
    end else begin
      case (in_state)
        FILL: begin
          if (s_fire) begin
            frame_buf[wr_cnt][0] <= s_data[0];
            frame_buf[wr_cnt][1] <= s_data[1];
            wr_cnt               <= wr_cnt + 4'd1;
            if (wr_cnt == 4'd15) begin
              s_ready <= 1'b0;
              if (out_free) begin
                in_state    <= ISSUE;
                fft_i_valid <= 1'b1;
                beat        <= '0;
                for (int i = 0; i < 4; i++) begin
                  for (int c = 0; c < 2; c++) begin
                    fft_i_data[i][c] <= frame_buf[{next_group, 2'(i)}][c];
                  end
                end
              end else begin
                in_state <= FULL;
              end
            end
          end
        end

        FULL: begin
          if (out_free) begin
            in_state    <= ISSUE;
            fft_i_valid <= 1'b1;
            beat        <= '0;
            for (int i = 0; i < 4; i++) begin
              for (int c = 0; c < 2; c++) begin
                fft_i_data[i][c] <= frame_buf[{next_group, 2'(i)}][c];
              end
            end
          end
        end

        // Valid must stay high for all five beats; the compute beat keeps beat 3's data.
        ISSUE: begin
          if (beat == 3'd4) begin
            in_state    <= WAIT;
            fft_i_valid <= 1'b0;
            wait_cnt    <= '0;
            for (int i = 0; i < 4; i++) begin
              for (int c = 0; c < 2; c++) begin
                fft_i_data[i][c] <= '0;
              end
            end
          end else begin
            beat <= beat + 3'd1;
            if (beat != 3'd3) begin
              for (int i = 0; i < 4; i++) begin
                for (int c = 0; c < 2; c++) begin
                  fft_i_data[i][c] <= frame_buf[{next_group, 2'(i)}][c];
                end
              end
            end
          end
        end

        WAIT: begin
          if (fft_o_valid) begin
            in_state <= FILL;
            s_ready  <= 1'b1;
            wr_cnt   <= '0;
          end else if (wait_cnt == 2'd3) begin
            err      <= 1'b1;
            in_state <= FILL;
            s_ready  <= 1'b1;
            wr_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        default: begin
          in_state <= FILL;
          s_ready  <= 1'b1;
          wr_cnt   <= '0;
        end
      endcase
    end
  end

  // Output side: capture all sixteen results at once, then present them in bin order.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      out_state <= IDLE;
      m_valid   <= 1'b0;
      m_index   <= '0;
      m_last    <= 1'b0;
      rd_cnt    <= '0;
      m_data[0] <= '0;
      m_data[1] <= '0;
    end else begin
      case (out_state)
        IDLE: begin
          if (start_drain) begin
            for (int k = 0; k < 16; k++) begin
              for (int c = 0; c < 2; c++) begin
                bin_buf[k][c] <= fft_o_data[k][c];
              end
            end
            out_state <= DRAIN;
            m_valid   <= 1'b1;
            rd_cnt    <= '0;
            m_index   <= '0;
            m_last    <= 1'b0;
            m_data[0] <= fft_o_data[0][0];
            m_data[1] <= fft_o_data[0][1];
          end
        end

        DRAIN: begin
          if (m_ready) begin
            if (rd_cnt == 4'd15) begin
              out_state <= IDLE;
              m_valid   <= 1'b0;
              rd_cnt    <= '0;
              m_index   <= '0;
              m_last    <= 1'b0;
              m_data[0] <= '0;
              m_data[1] <= '0;
            end else begin
              rd_cnt    <= rd_next;
              m_index   <= rd_next;
              m_last    <= (rd_next == 4'd15);
              m_data[0] <= bin_buf[rd_next][0];
              m_data[1] <= bin_buf[rd_next][1];
            end
          end
        end

        default: begin
          out_state <= IDLE;
          m_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer with a behavioural 16-point DFT core
// standing in for fft_16_4.
module tb_fft_frame_sequencer;

  localparam int  IW = 8;
  localparam int  OW = IW + 4;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int re;
    int im;
  } cplx_t;

  typedef struct {
    int re;
    int im;
    int idx;
  } bin_t;

  // One directed frame: input samples and hand-computed bins, 16-bit two's complement.
  typedef struct {
    logic [15:0][15:0] xr;
    logic [15:0][15:0] xi;
    logic [15:0][15:0] yr;
    logic [15:0][15:0] yi;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_sync;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [IW-1:0] s_data [2];
  logic                 m_valid;
  logic                 m_ready;
  logic signed [OW-1:0] m_data [2];
  logic [3:0]           m_index;
  logic                 m_last;
  logic                 err;
  logic                 fft_rst_sync_n;
  logic                 fft_i_valid;
  logic signed [IW-1:0] fft_i_data [4][2];
  logic                 fft_o_valid = 1'b0;
  logic signed [OW-1:0] fft_o_data [16][2];

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int acc_cnt = 0;
  int last_accept_cyc = 0;
  int mvalid_rise_cyc = 0;
  int issue_cyc = 0;
  int err_cyc = 0;
  int sready_low = 0;
  int last_low_run = 0;
  int mvalid_cycles = 0;
  logic prev_mvalid = 1'b0;
  logic prev_mready = 1'b0;
  logic prev_ivalid = 1'b0;
  logic prev_err = 1'b0;
  int prev_index = 0;
  int prev_re = 0;
  int prev_im = 0;

  cplx_t src_q[$];
  bin_t  exp_q[$];
  int    bin15_q[$];
  vec_t  vecs[7];

  logic core_mute = 1'b0;
  int   core_run = 0;
  int   ivalid_run = 0;
  int   rx_re[16];
  int   rx_im[16];
  int   cy_re[16];
  int   cy_im[16];

  always #5 clk = ~clk;

  fft_frame_sequencer #(.IW(IW), .OW(OW)) dut (
    .clk            (clk),
    .rst_sync       (rst_sync),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_index        (m_index),
    .m_last         (m_last),
    .err            (err),
    .fft_rst_sync_n (fft_rst_sync_n),
    .fft_i_valid    (fft_i_valid),
    .fft_i_data     (fft_i_data),
    .fft_o_valid    (fft_o_valid),
    .fft_o_data     (fft_o_data)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Unnormalised DFT scaled from 1.7 input to 8.4 output (divide by 8), rounded.
  function automatic void dft(input int xr[16], input int xi[16], output int yr[16], output int yi[16]);
    real sr;
    real si;
    real ang;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        ang = -2.0 * PI * real'(k * n) / 16.0;
        sr += real'(xr[n]) * $cos(ang) - real'(xi[n]) * $sin(ang);
        si += real'(xr[n]) * $sin(ang) + real'(xi[n]) * $cos(ang);
      end
      yr[k] = int'(sr / 8.0);
      yi[k] = int'(si / 8.0);
    end
  endfunction

  // Core model: needs five contiguous valid beats, answers one cycle later.
  always @(posedge clk) begin
    fft_o_valid <= 1'b0;
    if (!fft_rst_sync_n) begin
      core_run   = 0;
      ivalid_run = 0;
      for (int k = 0; k < 16; k++) begin
        fft_o_data[k][0] <= '0;
        fft_o_data[k][1] <= '0;
      end
    end else if (fft_i_valid) begin
      ivalid_run++;
      if (core_run < 4) begin
        for (int i = 0; i < 4; i++) begin
          rx_re[4*core_run+i] = int'(fft_i_data[i][0]);
          rx_im[4*core_run+i] = int'(fft_i_data[i][1]);
        end
      end
      core_run++;
      if (core_run == 5) begin
        dft(rx_re, rx_im, cy_re, cy_im);
        for (int k = 0; k < 16; k++) begin
          fft_o_data[k][0] <= cy_re[k][OW-1:0];
          fft_o_data[k][1] <= cy_im[k][OW-1:0];
        end
        fft_o_valid <= ~core_mute;
        core_run = 0;
      end
    end else begin
      if (ivalid_run > 0) checkOutput("issue_len", ivalid_run, 5);
      ivalid_run = 0;
      core_run   = 0;
    end
  end

  task automatic applyStimulus(input int xr[16], input int xi[16], input int yr[16],
                               input int yi[16], input bit with_exp);
    cplx_t c;
    bin_t  b;
    for (int n = 0; n < 16; n++) begin
      c.re = xr[n];
      c.im = xi[n];
      src_q.push_back(c);
    end
    if (with_exp) begin
      for (int k = 0; k < 16; k++) begin
        b.re  = yr[k];
        b.im  = yi[k];
        b.idx = k;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_row(input int r, input bit with_exp);
    int xr[16];
    int xi[16];
    int yr[16];
    int yi[16];
    for (int n = 0; n < 16; n++) begin
      xr[n] = int'($signed(vecs[r].xr[n]));
      xi[n] = int'($signed(vecs[r].xi[n]));
      yr[n] = int'($signed(vecs[r].yr[n]));
      yi[n] = int'($signed(vecs[r].yi[n]));
    end
    applyStimulus(xr, xi, yr, yi, with_exp);
  endtask

  task automatic run_random_frame();
    int xr[16];
    int xi[16];
    int yr[16];
    int yi[16];
    for (int n = 0; n < 16; n++) begin
      xr[n] = int'($urandom_range(255)) - 128;
      xi[n] = int'($urandom_range(255)) - 128;
    end
    dft(xr, xi, yr, yi);
    applyStimulus(xr, xi, yr, yi, 1'b1);
  endtask

  // One clock: observe the current cycle at the falling edge, then drive its inputs.
  task automatic step(input int sv_pct, input int mr_pct);
    cplx_t c;
    bin_t  e;
    @(negedge clk);
    cyc++;
    if (prev_mvalid && !prev_mready) begin
      checkOutput("stall_valid", int'(m_valid), 1);
      checkOutput("stall_index", int'(m_index), prev_index);
      checkOutput("stall_re", int'(m_data[0]), prev_re);
      checkOutput("stall_im", int'(m_data[1]), prev_im);
    end
    if (m_valid) mvalid_cycles++;
    if (m_valid && !prev_mvalid) mvalid_rise_cyc = cyc;
    if (fft_i_valid && !prev_ivalid) issue_cyc = cyc;
    if (err && !prev_err) err_cyc = cyc;
    if (!s_ready) begin
      sready_low++;
    end else begin
      if (sready_low > 0) last_low_run = sready_low;
      sready_low = 0;
    end

    s_valid = (src_q.size() > 0) && (int'($urandom_range(99)) < sv_pct);
    if (s_valid) begin
      c = src_q[0];
      s_data[0] = c.re[IW-1:0];
      s_data[1] = c.im[IW-1:0];
      if (s_ready) begin
        src_q.pop_front();
        acc_cnt++;
        if (acc_cnt % 16 == 0) last_accept_cyc = cyc;
      end
    end else begin
      s_data[0] = '0;
      s_data[1] = '0;
    end

    m_ready = (int'($urandom_range(99)) < mr_pct);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_bin", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("bin_index", int'(m_index), e.idx);
        checkOutput("bin_re", int'(m_data[0]), e.re);
        checkOutput("bin_im", int'(m_data[1]), e.im);
        checkOutput("bin_last", int'(m_last), (e.idx == 15) ? 1 : 0);
      end
      if (m_last) bin15_q.push_back(cyc);
    end

    prev_mvalid = m_valid;
    prev_mready = m_ready;
    prev_ivalid = fft_i_valid;
    prev_err    = err;
    prev_index  = int'(m_index);
    prev_re     = int'(m_data[0]);
    prev_im     = int'(m_data[1]);
  endtask

  task automatic run_until_drained(input int sv_pct, input int mr_pct, input int budget);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step(sv_pct, mr_pct);
      n++;
    end
    checkOutput("drain_budget", src_q.size() + exp_q.size(), 0);
  endtask

  task automatic do_reset();
    int nz = 0;
    @(negedge clk);
    s_valid   = 1'b0;
    m_ready   = 1'b0;
    s_data[0] = '0;
    s_data[1] = '0;
    rst_sync  = 1'b1;
    #1;
    checkOutput("core_rst_n", int'(fft_rst_sync_n), 0);
    @(negedge clk);
    checkOutput("rst_s_ready", int'(s_ready), 1);
    checkOutput("rst_m_valid", int'(m_valid), 0);
    checkOutput("rst_m_re", int'(m_data[0]), 0);
    checkOutput("rst_m_im", int'(m_data[1]), 0);
    checkOutput("rst_m_index", int'(m_index), 0);
    checkOutput("rst_m_last", int'(m_last), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_i_valid", int'(fft_i_valid), 0);
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (fft_i_data[i][c] != '0) nz++;
      end
    end
    checkOutput("rst_i_data_nonzero", nz, 0);
    rst_sync = 1'b0;
    src_q.delete();
    exp_q.delete();
    acc_cnt     = 0;
    sready_low  = 0;
    prev_mvalid = 1'b0;
    prev_mready = 1'b0;
    prev_ivalid = 1'b0;
    prev_err    = 1'b0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_sync  = 1'b1;
    s_valid   = 1'b0;
    m_ready   = 1'b0;
    s_data[0] = '0;
    s_data[1] = '0;

    for (int r = 0; r < 7; r++) begin
      vecs[r].xr = '0;
      vecs[r].xi = '0;
      vecs[r].yr = '0;
      vecs[r].yi = '0;
    end
    // Impulse of 0.5: every bin 0.5 = 8 in 8.4.
    vecs[0].xr[0] = 16'(64);
    for (int k = 0; k < 16; k++) vecs[0].yr[k] = 16'(8);
    // DC of 0.5: bin 0 = 16 * 0.5 = 8.0 = 128.
    for (int k = 0; k < 16; k++) vecs[1].xr[k] = 16'(64);
    vecs[1].yr[0] = 16'(128);
    // Alternating +/-0.5: all energy in bin 8.
    for (int k = 0; k < 16; k++) vecs[2].xr[k] = (k % 2 == 0) ? 16'(64) : 16'(-64);
    vecs[2].yr[8] = 16'(128);
    // Cosine at bin 4: 0.5, 0, -0.5, 0 ... -> bins 4 and 12 = 4.0 = 64.
    for (int k = 0; k < 16; k++)
      vecs[3].xr[k] = (k % 4 == 0) ? 16'(64) : ((k % 4 == 2) ? 16'(-64) : 16'(0));
    vecs[3].yr[4]  = 16'(64);
    vecs[3].yr[12] = 16'(64);
    // Imaginary impulse.
    vecs[4].xi[0] = 16'(64);
    for (int k = 0; k < 16; k++) vecs[4].yi[k] = 16'(8);
    // Full-scale negative impulse: -1.0 -> -16.
    vecs[5].xr[0] = 16'(-128);
    for (int k = 0; k < 16; k++) vecs[5].yr[k] = 16'(-16);
    // Imaginary DC of -0.25: bin 0 = -4.0 = -64.
    for (int k = 0; k < 16; k++) vecs[6].xi[k] = 16'(-32);
    vecs[6].yi[0] = 16'(-64);

    repeat (2) @(negedge clk);
    do_reset();

    $display("[TB] directed frames");
    for (int r = 0; r < 7; r++) begin
      run_row(r, 1'b1);
      run_until_drained(100, 100, 200);
      checkOutput("first_bin_latency", mvalid_rise_cyc - last_accept_cyc, 7);
      checkOutput("s_ready_low_run", last_low_run, 6);
    end

    $display("[TB] gappy input with backpressure");
    for (int f = 0; f < 3; f++) run_random_frame();
    run_until_drained(50, 30, 3000);

    $display("[TB] overlap with stalled drain");
    bin15_q.delete();
    run_row(1, 1'b1);
    run_row(0, 1'b1);
    n = 0;
    while (src_q.size() > 0 && n < 300) begin
      step(100, 0);
      n++;
    end
    checkOutput("overlap_fill_budget", src_q.size(), 0);
    repeat (4) step(100, 0);
    checkOutput("overlap_full_s_ready", int'(s_ready), 0);
    checkOutput("overlap_no_issue", int'(fft_i_valid), 0);
    run_until_drained(100, 100, 300);
    checkOutput("overlap_frames_done", bin15_q.size(), 2);
    if (bin15_q.size() > 0) checkOutput("overlap_issue_start", issue_cyc, bin15_q[0] + 1);

    $display("[TB] reset mid-frame");
    run_row(5, 1'b0);
    while (src_q.size() > 7) step(100, 100);
    do_reset();
    run_row(3, 1'b1);
    run_until_drained(100, 100, 200);

    $display("[TB] reset during drain");
    run_row(1, 1'b1);
    n = 0;
    while (!m_valid && n < 100) begin
      step(100, 0);
      n++;
    end
    checkOutput("drain_reached", int'(m_valid), 1);
    repeat (3) step(100, 100);
    do_reset();
    run_row(4, 1'b1);
    run_until_drained(100, 100, 200);

    $display("[TB] core timeout");
    core_mute = 1'b1;
    mvalid_cycles = 0;
    run_row(0, 1'b0);
    repeat (40) step(100, 100);
    checkOutput("timeout_err_cycle", err_cyc - last_accept_cyc, 10);
    checkOutput("timeout_err", int'(err), 1);
    checkOutput("timeout_no_m_valid", mvalid_cycles, 0);
    checkOutput("timeout_s_ready", int'(s_ready), 1);
    core_mute = 1'b0;
    run_row(2, 1'b1);
    run_until_drained(100, 100, 200);
    checkOutput("err_sticky", int'(err), 1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Controller that sequences the size-16, 4-samples-per-beat FFT core (`fft_16_4`) from a one-sample-per-cycle valid/ready stream. It collects 16 complex input samples and issues them to the core as four contiguous 4-sample beats plus the compute beat. It then captures the 16 parallel results and drains them as a one-bin-per-cycle valid/ready stream. It sits between the sample source and the downstream bin consumer; the core is instantiated beside it and wired through the `fft_*` ports.

## Interface
- `IW`, default 8: input sample width; signed fixed point with 1 sign bit and 7 fractional bits.
- `OW`, default `IW+4`: output bin width; signed fixed point with 8 integer bits and 4 fractional bits.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst_sync`  in  1: reset, synchronous and active-high.
- `s_valid`  in  1: input sample valid.
- `s_ready`  out  1: input sample accepted when `s_valid & s_ready`.
- `s_data[2]`  in  IW each: input sample; `[0]` real, `[1]` imaginary.
- `m_valid`  out  1: output bin valid.
- `m_ready`  in  1: consumer accepts the bin when `m_valid & m_ready`.
- `m_data[2]`  out  OW each: output bin; `[0]` real, `[1]` imaginary.
- `m_index`  out  4: bin number, 0..15.
- `m_last`  out  1: high with bin 15.
- `err`  out  1: sticky core-timeout flag.
- `fft_rst_sync_n`  out  1: core reset; combinationally `~rst_sync`.
- `fft_i_valid`  out  1: core input valid.
- `fft_i_data[4][2]`  out  IW each: core input beat.
- `fft_o_valid`  in  1: core output valid.
- `fft_o_data[16][2]`  in  OW each: core results.

## Operation
- Input FSM states: FILL, FULL, ISSUE, WAIT.
- **FILL**
  - `s_ready=1`.
  - Each accepted sample is written to frame buffer slot `wr_cnt`, and `wr_cnt` increments.
  - On the 16th accept, go to ISSUE if the output FSM is IDLE that cycle; otherwise go to FULL.
- **FULL**
  - `s_ready=0`.
  - Go to ISSUE in the first cycle the output FSM is IDLE.
- **ISSUE**
  - Five consecutive cycles, tracked by `beat` 0..4. `fft_i_valid=1` in all five.
  - Beats 0..3 drive buffer slots `4*beat+i` onto `fft_i_data[i]`.
  - Beat 4 is the compute beat; it re-drives the beat-3 data.
  - `fft_i_valid` never drops inside ISSUE, because the core restarts on any gap.
  - After beat 4, go to WAIT.
- **WAIT**
  - `fft_i_valid=0`, `s_ready=0`.
  - If `fft_o_valid=1`, capture all 16 `fft_o_data` bins into the output buffer, start the output FSM in DRAIN, clear `wr_cnt`, and go to FILL.
  - If `fft_o_valid` is not seen within 4 WAIT cycles: set `err=1`, discard the frame, and go to FILL.
- Output FSM states: IDLE, DRAIN.
- **DRAIN**
  - `m_valid=1`.
  - `m_data` is output buffer entry `rd_cnt`; `m_index=rd_cnt`; `m_last=(rd_cnt==15)`.
  - `rd_cnt` advances on each handshake.
  - After bin 15 is accepted, go to IDLE.
- Input filling of the next frame overlaps DRAIN.
- No arithmetic in this block; bins pass through unmodified.
- `fft_i_data` is driven 0 outside ISSUE.
- Reset mid-operation:
  - Any partial input frame and any undrained bins are discarded.
  - The core is reset in the same cycle via `fft_rst_sync_n`.
  - `err` is cleared only by reset.

## Timing
- Reset values: `s_ready=1` (FILL), `m_valid=0`, `m_data=0`, `m_index=0`, `m_last=0`, `err=0`, `fft_i_valid=0`, `fft_i_data=0`.
- Let cycle A be the cycle in which the 16th sample is accepted, with the output FSM IDLE. Then:
  - ISSUE occupies A+1..A+5.
  - Core `fft_o_valid` rises in A+6 (WAIT); capture happens at the end of A+6.
  - `m_valid=1` with bin 0 in A+7, so latency from the 16th accept to the first bin is 7 cycles.
  - `s_ready` is low A+1..A+6 and high again in A+7.
- With `m_ready=1` continuously, bins 0..15 appear in A+7..A+22.
- Back-to-back throughput is limited by DRAIN: the next ISSUE may start no earlier than the cycle after bin 15 is accepted.
- Bins are never skipped or repeated under `m_ready` backpressure; `m_data` and `m_index` are held stable while `m_valid & ~m_ready`.

## Test plan
- **Impulse:** sample 0 = (64,0), i.e. 0.5; samples 1..15 = 0; `m_ready=1` → 16 bins, each (8,0), `m_index` 0..15, `m_last` only on index 15, first bin 7 cycles after the 16th accept.
- **DC:** all 16 samples (64,0) → bin 0 = (128,0), bins 1..15 = (0,0); `s_ready` low for exactly 6 cycles.
- **Gappy input plus backpressure:** `s_valid` random 50%, `m_ready` random 30% → every bin is delivered exactly once in order; `m_data` is stable during stalls; `fft_i_valid` is high for exactly 5 contiguous cycles per frame.
- **Overlap:** stream frame 2 while frame 1 drains with `m_ready=0` → frame 2 waits in FULL with `s_ready=0`; ISSUE starts the cycle after bin 15 of frame 1 is accepted; frame 2 results are correct.
- **Reset mid-frame:** assert `rst_sync` after 9 samples, and again during DRAIN → all outputs take their reset values the next cycle and `fft_rst_sync_n=0` during reset; a following full frame produces correct bins.
- **Timeout:** hold `fft_o_valid=0` → `err=1` after 4 WAIT cycles, no `m_valid`, state returns to FILL with `s_ready=1`; `err` stays set until reset.
